// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32 type definitions for the M-extension multiply/divide unit.
package rv32i_types;
  localparam logic [6:0] M_EXT_FUNCT7 = 7'b0000001;
  typedef enum logic [2:0] {
    F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU, F3_DIV, F3_DIVU, F3_REM, F3_REMU
  } muldiv_funct3_t;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} muldiv_state_t;
endpackage

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit that stalls EX until its result is registered.
module ex_muldiv_unit
  import rv32i_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  muldiv_state_t    r_state;
  muldiv_funct3_t   r_op;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_a, r_b, r_rem, r_quo;
  logic [2*WIDTH-1:0] r_prod;
  logic             r_sa, r_sb;
  logic             w_sa, w_sb, w_div0, w_ovf, w_fast, w_last;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_fast_res, w_rem_nx, w_quo_nx, w_quo_fin, w_rem_fin, w_res_fin;
  logic [WIDTH:0]   w_sum, w_shift, w_sub;
  logic [2*WIDTH-1:0] w_prod_nx, w_prod_fin;
  assign stall_o = start_i & (r_state != DONE) & ~flush_i;
  assign done_o  = r_state == DONE;
  // Operand A is signed except for MULHU/DIVU/REMU; B is signed only for MUL/MULH/DIV/REM.
  always_comb begin
    w_sa       = ~(funct3_i[0] & (funct3_i[1] | funct3_i[2])) & rs1_i[WIDTH-1];
    w_sb       = (funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1]) & rs2_i[WIDTH-1];
    w_a_mag    = w_sa ? -rs1_i : rs1_i;
    w_b_mag    = w_sb ? -rs2_i : rs2_i;
    w_div0     = rs2_i == '0;
    w_ovf      = ~funct3_i[0] & (rs1_i == MIN) & (rs2_i == {WIDTH{1'b1}});
    w_fast     = funct3_i[2] & (w_div0 | w_ovf);
    w_fast_res = w_div0 ? (funct3_i[1] ? rs1_i : {WIDTH{1'b1}}) : (funct3_i[1] ? '0 : MIN);
  end
  always_comb begin
    w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_prod[0] ? r_a : '0};
    w_prod_nx  = {w_sum, r_prod[WIDTH-1:1]};
    w_prod_fin = (r_sa ^ r_sb) ? -w_prod_nx : w_prod_nx;
  end
  // Restoring step: keep the shifted remainder whenever the trial subtraction borrows.
  always_comb begin
    w_shift   = {r_rem, r_quo[WIDTH-1]};
    w_sub     = w_shift - {1'b0, r_b};
    w_rem_nx  = w_sub[WIDTH] ? w_shift[WIDTH-1:0] : w_sub[WIDTH-1:0];
    w_quo_nx  = {r_quo[WIDTH-2:0], ~w_sub[WIDTH]};
    w_quo_fin = (r_sa ^ r_sb) ? -w_quo_nx : w_quo_nx;
    w_rem_fin = r_sa ? -w_rem_nx : w_rem_nx;
  end
  always_comb begin
    w_last    = &r_count;
    w_res_fin = (r_state == MUL) ? ((r_op == F3_MUL) ? w_prod_fin[WIDTH-1:0] : w_prod_fin[2*WIDTH-1:WIDTH])
                                 : (r_op[1] ? w_rem_fin : w_quo_fin);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= F3_MUL;
      r_count  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_prod   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      result_o <= '0;
    end else if (flush_i) begin
      r_state <= IDLE;
      r_count <= '0;
    end else if (r_state == IDLE) begin
      if (start_i) begin
        r_state <= w_fast ? DONE : (funct3_i[2] ? DIV : MUL);
        r_op    <= muldiv_funct3_t'(funct3_i);
        r_count <= '0;
        r_a     <= w_a_mag;
        r_b     <= w_b_mag;
        r_sa    <= w_sa;
        r_sb    <= w_sb;
        r_prod  <= {{WIDTH{1'b0}}, w_b_mag};
        r_rem   <= '0;
        r_quo   <= w_a_mag;
        if (w_fast) result_o <= w_fast_res;
      end
    end else if (r_state == DONE) begin
      r_state <= IDLE;
    end else begin
      r_count <= r_count + 1'b1;
      if (r_state == MUL) r_prod <= w_prod_nx;
      else begin
        r_rem <= w_rem_nx;
        r_quo <= w_quo_nx;
      end
      if (w_last) begin
        r_state  <= DONE;
        result_o <= w_res_fin;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed scoreboard bench for the iterative multiply/divide unit.
module tb_ex_muldiv_unit;
  import rv32i_types::*;
  logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, flush_i = 1'b0;
  logic [2:0] funct3_i = 3'd0;
  logic [31:0] rs1_i = '0, rs2_i = '0;
  logic stall_o, done_o;
  logic [31:0] result_o;
  int checks = 0, errors = 0, cyc = 0, last_done = 0, prev_done = 0;
  bit seen;
  logic [31:0] sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .funct3_i(funct3_i), .rs1_i(rs1_i),
    .rs2_i(rs2_i), .flush_i(flush_i), .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Drives one op from cycle 0, scrambles operands while it runs, and checks latency/result on done_o.
  task automatic op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp, input int lat);
    int n;
    bit got, stall_bad;
    start_i = 1'b1; funct3_i = f; rs1_i = a; rs2_i = b;
    sb.push_back(exp);
    n = 0; got = 0; stall_bad = 0;
    while (!got && n <= 40) begin
      @(negedge clk);
      if (done_o) begin
        got = 1;
        last_done = cyc;
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_stall_at_done"}, stall_o, 1'b0);
        chk({tag, "_result"}, result_o, sb.pop_front());
      end else if (!stall_o) stall_bad = 1;
      @(posedge clk); #1;
      if (!got) begin
        n++;
        if (n >= 2) begin rs1_i = $urandom; rs2_i = $urandom; end
      end
    end
    chk({tag, "_done_seen"}, got, 1'b1);
    if (!got) void'(sb.pop_front());
    chk({tag, "_stall_during_op"}, stall_bad, 1'b0);
    start_i = 1'b0;
  endtask
  initial begin
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_done", done_o, 1'b0);
    chk("rst_result", result_o, 32'h0);
    chk("rst_stall_low", stall_o, 1'b0);
    @(posedge clk); #1;
    start_i = 1'b1;
    @(negedge clk);
    chk("rst_stall_follows_start", stall_o, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0; start_i = 1'b0;
    op("mul_7x6",     3'b000, 32'd7, 32'd6, 32'd42, 33);
    op("mulh_m1m1",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33);
    op("mulhu_m1m1",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    op("mulhsu_m1x2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
    op("mul_m3x5",    3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 33);
    op("div_m7d2",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    op("rem_m7d2",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    op("divu_100d7",  3'b101, 32'd100, 32'd7, 32'd14, 33);
    op("remu_100d7",  3'b111, 32'd100, 32'd7, 32'd2, 33);
    op("div_min_d2",  3'b100, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);
    op("divu_5d0",    3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    op("remu_9d0",    3'b111, 32'd9, 32'd0, 32'd9, 1);
    start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd5; rs2_i = 32'd0;
    @(negedge clk);
    chk("idle_flush_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    flush_i = 1'b0; start_i = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_o) seen = 1;
    end
    chk("idle_flush_no_accept", seen, 1'b0);
    @(posedge clk); #1;
    start_i = 1'b1; funct3_i = 3'b100; rs1_i = 32'd1000; rs2_i = 32'd3;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_o) seen = 1;
      @(posedge clk); #1;
    end
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_div_stall", stall_o, 1'b0);
    chk("flush_div_no_done", seen | done_o, 1'b0);
    chk("flush_result_held", result_o, 32'd9);
    @(posedge clk); #1;
    flush_i = 1'b0;
    op("mul_3x3_after_flush", 3'b000, 32'd3, 32'd3, 32'd9, 33);
    start_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd123; rs2_i = 32'd456;
    repeat (20) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_mul_no_done", done_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_mul_done_next", done_o, 1'b0);
    chk("rst_mid_mul_result", result_o, 32'h0);
    @(posedge clk); #1;
    op("b2b_2x3", 3'b000, 32'd2, 32'd3, 32'd6, 33);
    prev_done = last_done;
    op("b2b_4x5", 3'b000, 32'd4, 32'd5, 32'd20, 33);
    chk("b2b_gap", last_done - prev_done, 32'd34);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
